// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared binary32 field constants, special-value helpers and
//               the accumulator state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int          FP_SIGN     = 31;
    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } acc_state_t;

    // Exponent all ones with a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF) && (x[FP_EXP_LSB-1:0] != 23'd0);
    endfunction

    // Exponent all ones with a zero fraction.
    function automatic logic is_inf(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF) && (x[FP_EXP_LSB-1:0] == 23'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/FP_Add.sv
// ============================================================================
// Module      : FP_Add
// Description : Combinational IEEE-754 binary32 adder, round-to-nearest-even,
//               subnormal aware, quiet-NaN (7FC00000) on invalid results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module FP_Add (
    input  logic [31:0] a_original,
    input  logic [31:0] b_original,
    output logic [31:0] sum
);

    logic        a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_big;
    logic        big_sign, small_sign, shift_sticky, sticky_c, round_up, found;
    logic [7:0]  big_eff, small_eff, diff, max_shift, exp_field;
    logic [23:0] big_sig, small_sig;
    logic [26:0] small_ext, small_shift, norm;
    logic [27:0] raw;
    logic [9:0]  exp_n;
    logic [4:0]  lz, lshift;
    logic [30:0] packed_mag;

    // Align, add/subtract magnitudes, normalise, round and pack.
    always_comb begin
        a_sign = a_original[31];
        b_sign = b_original[31];
        a_nan  = (a_original[30:23] == 8'hFF) && (a_original[22:0] != 23'd0);
        b_nan  = (b_original[30:23] == 8'hFF) && (b_original[22:0] != 23'd0);
        a_inf  = (a_original[30:23] == 8'hFF) && (a_original[22:0] == 23'd0);
        b_inf  = (b_original[30:23] == 8'hFF) && (b_original[22:0] == 23'd0);

        // Raw magnitude bits order the same way as the values they encode.
        a_big = (a_original[30:0] >= b_original[30:0]);
        if (a_big) begin
            big_sign   = a_sign;
            small_sign = b_sign;
            big_eff    = (a_original[30:23] == 8'd0) ? 8'd1 : a_original[30:23];
            small_eff  = (b_original[30:23] == 8'd0) ? 8'd1 : b_original[30:23];
            big_sig    = {(a_original[30:23] != 8'd0), a_original[22:0]};
            small_sig  = {(b_original[30:23] != 8'd0), b_original[22:0]};
        end else begin
            big_sign   = b_sign;
            small_sign = a_sign;
            big_eff    = (b_original[30:23] == 8'd0) ? 8'd1 : b_original[30:23];
            small_eff  = (a_original[30:23] == 8'd0) ? 8'd1 : a_original[30:23];
            big_sig    = {(b_original[30:23] != 8'd0), b_original[22:0]};
            small_sig  = {(a_original[30:23] != 8'd0), a_original[22:0]};
        end

        // Three extra bits (guard, round, sticky) below the significand.
        diff      = big_eff - small_eff;
        small_ext = {small_sig, 3'b000};
        if (diff >= 8'd27) begin
            small_shift  = 27'd0;
            shift_sticky = |small_sig;
        end else begin
            small_shift  = small_ext >> diff;
            shift_sticky = |(small_ext & ~(27'h7FFFFFF << diff));
        end
        small_shift = small_shift | {26'd0, shift_sticky};

        if (big_sign == small_sign) begin
            raw = {1'b0, big_sig, 3'b000} + {1'b0, small_shift};
        end else begin
            raw = {1'b0, big_sig, 3'b000} - {1'b0, small_shift};
        end

        // Leading-zero count of the 27-bit result below the carry bit.
        lz    = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && raw[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        // Left shift is capped so the exponent never drops below the subnormal floor.
        max_shift = big_eff - 8'd1;
        if ({3'b000, lz} > max_shift) begin
            lshift = max_shift[4:0];
        end else begin
            lshift = lz;
        end

        if (raw[27]) begin
            norm     = raw[27:1];
            sticky_c = raw[0];
            exp_n    = {2'b00, big_eff} + 10'd1;
        end else begin
            norm     = raw[26:0] << lshift;
            sticky_c = 1'b0;
            exp_n    = {2'b00, big_eff} - {5'd0, lshift};
        end

        // Rounding carry ripples into the exponent, covering subnormal->normal and ->inf.
        exp_field  = norm[26] ? exp_n[7:0] : 8'd0;
        round_up   = norm[2] & (norm[1] | norm[0] | sticky_c | norm[3]);
        packed_mag = {exp_field, norm[25:3]} + {30'd0, round_up};

        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            sum = 32'h7FC00000;
        end else if (a_inf) begin
            sum = a_original;
        end else if (b_inf) begin
            sum = b_original;
        end else if (raw == 28'd0) begin
            sum = {a_sign & b_sign, 31'd0};
        end else if (exp_n >= 10'd255) begin
            sum = {big_sign, 8'hFF, 23'd0};
        end else begin
            sum = {big_sign, packed_mag};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_accumulator.sv
// ============================================================================
// Module      : fp_accumulator
// Description : Streaming binary32 accumulator around FP_Add with valid/ready
//               input and output handshakes, beat count and sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_accumulator
    import fp_pkg::*;
#(
    parameter int DATAWIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   in_data,
    input  logic                   in_sub,
    input  logic                   in_last,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAWIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_nan,
    output logic                   out_inf
);

    acc_state_t             state;
    logic [DATAWIDTH-1:0]   acc;
    logic [DATAWIDTH-1:0]   operand;
    logic [DATAWIDTH-1:0]   sum;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   nan_flag;
    logic                   nan_next;
    logic                   beat;

    // Subtraction is folded into the operand by flipping its sign bit.
    assign operand    = {in_data[FP_SIGN] ^ in_sub, in_data[FP_SIGN-1:0]};
    assign in_ready   = (state == ST_ACCUM) && !clear;
    assign beat       = in_valid && in_ready;
    assign count_next = (&count) ? count : count + 1'b1;
    assign nan_next   = nan_flag | is_nan(operand) | is_nan(sum);

    FP_Add u_fp_add (
        .a_original (acc),
        .b_original (operand),
        .sum        (sum)
    );

    // Accumulate / present / re-arm state machine with registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_ACCUM;
            acc       <= FP_POS_ZERO;
            count     <= '0;
            nan_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_nan   <= 1'b0;
            out_inf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (clear) begin
                        acc      <= FP_POS_ZERO;
                        count    <= '0;
                        nan_flag <= 1'b0;
                    end else if (beat) begin
                        acc      <= sum;
                        count    <= count_next;
                        nan_flag <= nan_next;
                        if (in_last) begin
                            out_data  <= sum;
                            out_count <= count_next;
                            out_nan   <= nan_next;
                            out_inf   <= is_inf(sum) && !nan_next;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= FP_POS_ZERO;
                        count     <= '0;
                        nan_flag  <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Streaming single-precision accumulator directly downstream of the combinational FP_Add adder.
- Accepts a stream of IEEE-754 binary32 operands over a valid/ready handshake and folds each one into a running sum. The sum is fed back as FP_Add's first operand.
- On a beat marked last, presents the final sum, beat count and sticky special-value flags on an output handshake, then re-arms for the next stream.

Parameters:
- DATAWIDTH, 32, operand/result width; only 32 (binary32) is supported.
- COUNT_WIDTH, 16, width of the accepted-beat counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATAWIDTH  binary32 operand.
- in_sub  input  1  1 = subtract in_data from the running sum; implemented by inverting bit 31.
- in_last  input  1  beat closes the current stream.
- clear  input  1  synchronous abort of the current stream.
- out_valid  output  1  final result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATAWIDTH  final sum.
- out_count  output  COUNT_WIDTH  number of beats accepted in the stream.
- out_nan  output  1  a NaN was seen in any operand or partial sum.
- out_inf  output  1  a final sum is ±infinity and out_nan=0.

Behaviour:
- Interface timing: single clock. Reset is asynchronous and active-low. All state is registered; out_* are driven straight from registers.
- States: ACCUM, DONE. Reset -> ACCUM.
- Reset values:
  - acc = 32'h00000000 (+0).
  - count = 0.
  - nan_flag = 0.
  - out_valid = 0.
  - out_data = 0, out_count = 0, out_nan = 0, out_inf = 0.
- Adder hookup: one FP_Add instance.
  - a_original = acc.
  - b_original = {in_data[31]^in_sub, in_data[30:0]}.
  - sum is combinational.
- in_ready = (state==ACCUM) && !clear.
- ACCUM, beat accepted (in_valid && in_ready):
  - acc <= sum.
  - count <= count+1, saturating at all-ones.
  - nan_flag is set if the operand is NaN (exp==8'hFF, mantissa!=0) or sum is NaN.
- ACCUM, accepted beat with in_last=1, additionally:
  - out_data <= sum.
  - out_count <= count+1 (saturated).
  - out_nan <= the updated nan_flag.
  - out_inf <= (sum exp==8'hFF && mantissa==0 && !updated nan_flag).
  - out_valid <= 1; state -> DONE.
- Latency: result is visible the cycle after the last beat. Throughput is one beat per cycle in ACCUM.
- DONE:
  - in_ready=0; out_* held stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0, acc <= +0, count <= 0, nan_flag <= 0, state -> ACCUM.
  - The next beat is accepted no earlier than the cycle after the handshake.
- clear in ACCUM: acc <= +0, count <= 0, nan_flag <= 0. No beat is accepted that cycle because in_ready is low. clear in DONE is ignored.
- Boundary conditions:
  - Empty stream is impossible; a stream always has at least one beat.
  - A single last beat yields out_data = ±in_data as adjusted by in_sub, and out_count = 1.
  - Count saturation does not stop accumulation.
  - Reset asserted mid-stream or mid-DONE discards everything immediately, asynchronously.
  - out_valid must never assert without a preceding last beat.
- Arithmetic rounding and normalisation are entirely FP_Add's. This block never alters sum bits except for the sign inversion on the operand path.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP_EXP_MSB=30, FP_EXP_LSB=23, FP_SIGN=31, FP_POS_ZERO=32'h00000000;
  - functions is_nan(x) and is_inf(x);
  - a typedef for the two-state enum.
- The sub-module is the existing FP_Add, instantiated once and unchanged. No further sub-modules.

Test Plan:
- 1.0 (3F800000) then 2.0 (40000000, last) -> out_data=40400000, out_count=2, flags 0, out_valid one cycle after the last beat.
- 1.0 then in_sub=1 with 2.0, last -> BF800000 (-1.0), out_count=2.
- 1.0, 2.0, then -2.0 with in_sub=1 (last) -> 40A00000 (5.0). Hold out_ready=0 for 5 cycles: out_* stable, in_ready=0. Then out_ready=1 -> next stream starts from +0.
- 2.0, assert clear, then 1.0 with last -> 3F800000, out_count=1. Also verify in_ready=0 during the clear cycle.
- 1.0, NaN (7FC00000), 2.0 last -> out_nan=1, out_inf=0. Then 7F7FFFFF + 7F7FFFFF last -> out_inf=1 with out_data=7F800000.
- Drop Reset_n mid-stream (after 2 beats) and mid-DONE -> all outputs return to reset values immediately. The next stream 3F800000 last -> 3F800000, count 1.
